// File: rtl/ins_seq_detector.sv
// Overlapping serial pattern detector: consumes W stream bits per word (MSB oldest), emits a registered match mask.
// Optional build macro INS_MATCH_COUNT_EN adds a registered population count of the mask (match_cnt).
module ins_seq_detector #(
    parameter int         W       = 8,
    parameter logic [3:0] PATTERN = 4'b1010
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in,
    output logic [W-1:0] out,
    output logic         out_valid
`ifdef INS_MATCH_COUNT_EN
    ,
    output logic [3:0]   match_cnt
`endif
);

    logic [2:0]   hist_r;
    logic         hv_r;
    logic [W-1:0] out_r;
    logic         out_valid_r;
    logic [W+2:0] ext_s;
    logic [W-1:0] match_s;

`ifdef INS_MATCH_COUNT_EN
    logic [3:0]   match_cnt_r;

    function automatic logic [3:0] popcount(input logic [W-1:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < W; i++) begin
            c = c + {3'b000, m[i]};
        end
        return c;
    endfunction
`endif

    // Window evaluation over history plus the current word; windows touching stale history are suppressed
    always_comb begin
        ext_s   = {hist_r, in};
        match_s = {W{1'b0}};
        for (int i = 0; i < W; i++) begin
            if (!hv_r && (i >= W - 3)) begin
                match_s[i] = 1'b0;
            end else begin
                match_s[i] = (ext_s[i +: 4] == PATTERN);
            end
        end
    end

    // Result and history registers; history survives idle gaps so cross-word matches still land
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r       <= {W{1'b0}};
            out_valid_r <= 1'b0;
            hist_r      <= 3'b000;
            hv_r        <= 1'b0;
        end else if (in_valid) begin
            out_r       <= match_s;
            out_valid_r <= 1'b1;
            hist_r      <= in[2:0];
            hv_r        <= 1'b1;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef INS_MATCH_COUNT_EN
    // Match count register, updated alongside the mask
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt_r <= 4'd0;
        end else if (in_valid) begin
            match_cnt_r <= popcount(match_s);
        end else begin
            match_cnt_r <= match_cnt_r;
        end
    end

    assign match_cnt = match_cnt_r;
`endif

    assign out       = out_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_ins_seq_detector.sv
// Directed self-checking bench for ins_seq_detector; expected masks worked out by hand for pattern 1010.
module tb_ins_seq_detector;

    logic       clk_s;
    logic       rst_s;
    logic       in_valid_s;
    logic [7:0] in_s;
    logic [7:0] out_s;
    logic       out_valid_s;
`ifdef INS_MATCH_COUNT_EN
    logic [3:0] match_cnt_s;
`endif

    int n_assert;
    int n_fail;

    ins_seq_detector dut (
        .clk       (clk_s),
        .rst       (rst_s),
        .in_valid  (in_valid_s),
        .in        (in_s),
        .out       (out_s),
        .out_valid (out_valid_s)
`ifdef INS_MATCH_COUNT_EN
        ,
        .match_cnt (match_cnt_s)
`endif
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic apply(input logic r, input logic v, input logic [7:0] d);
        rst_s      = r;
        in_valid_s = v;
        in_s       = d;
        @(posedge clk_s);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [3:0] exp);
`ifdef INS_MATCH_COUNT_EN
        check(tag, {4'd0, match_cnt_s}, {4'd0, exp});
`else
        if (exp === 4'bxxxx) $display("unreachable %s", tag);
`endif
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst_s      = 1'b1;
        in_valid_s = 1'b0;
        in_s       = 8'h00;

        apply(1'b1, 1'b0, 8'h00);
        apply(1'b1, 1'b0, 8'h00);
        check("reset_out", out_s, 8'b00000000);
        check("reset_ov", {7'd0, out_valid_s}, 8'd0);
        check_cnt("reset_cnt", 4'd0);

        apply(1'b0, 1'b1, 8'b01101010);
        check("w1_out", out_s, 8'b00000101);
        check("w1_ov", {7'd0, out_valid_s}, 8'd1);
        check_cnt("w1_cnt", 4'd2);

        apply(1'b0, 1'b1, 8'b10101010);
        check("w2_cross", out_s, 8'b01010101);
        check("w2_ov", {7'd0, out_valid_s}, 8'd1);
        check_cnt("w2_cnt", 4'd4);

        apply(1'b0, 1'b1, 8'b00101010);
        check("w3_out", out_s, 8'b00000101);
        check_cnt("w3_cnt", 4'd2);

        for (int g = 0; g < 3; g++) begin
            apply(1'b0, 1'b0, 8'hff);
            check("gap_ov", {7'd0, out_valid_s}, 8'd0);
            check("gap_hold", out_s, 8'b00000101);
            check_cnt("gap_cnt", 4'd2);
        end

        apply(1'b0, 1'b1, 8'b10101010);
        check("after_gap", out_s, 8'b01010101);
        check("after_gap_ov", {7'd0, out_valid_s}, 8'd1);

        // reset wins over a simultaneous valid word
        apply(1'b1, 1'b1, 8'b10101010);
        check("rst_out", out_s, 8'b00000000);
        check("rst_ov", {7'd0, out_valid_s}, 8'd0);
        check_cnt("rst_cnt", 4'd0);

        apply(1'b0, 1'b1, 8'b10101010);
        check("post_rst_mask", out_s, 8'b00010101);
        check("post_rst_ov", {7'd0, out_valid_s}, 8'd1);
        check_cnt("post_rst_cnt", 4'd3);

        apply(1'b0, 1'b1, 8'b11111111);
        check("ones", out_s, 8'b00000000);
        check_cnt("ones_cnt", 4'd0);

        apply(1'b0, 1'b1, 8'b00000000);
        check("zeros", out_s, 8'b00000000);
        check("zeros_ov", {7'd0, out_valid_s}, 8'd1);
        check_cnt("zeros_cnt", 4'd0);

        // hist=000 now; 0101 in the low bits then a word whose top bits complete 1010 across the boundary
        apply(1'b0, 1'b1, 8'b00000101);
        check("lead", out_s, 8'b00000000);
        apply(1'b0, 1'b1, 8'b01000000);
        check("cross_hi", out_s, 8'b10100000);

        apply(1'b0, 1'b0, 8'h00);
        check("idle_ov", {7'd0, out_valid_s}, 8'd0);
        check("idle_hold", out_s, 8'b10100000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ins_seq_detector.md
Name: ins_seq_detector

Overview:
- Clocked overlapping sequence detector for the 4-bit pattern 1010 (default) over a serial bit stream delivered 8 bits per word, MSB first.
- Each accepted word yields an 8-bit match mask. Each mask bit marks a stream position where the pattern completes.
- The last 3 bits of the previous word are carried, so matches that span word boundaries are detected.
- Sits between a byte-wide deserializer and downstream event logic.

Parameters:
- W, 8, word width; the stream is consumed W bits per accepted word.
- PATTERN, 4'b1010, pattern to detect; PATTERN[3] is the oldest bit in the stream.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  qualifies in for this cycle
- in  input  W  data word; in[W-1] is the oldest bit, in[0] the newest
- out  output  W  registered match mask
- out_valid  output  1  out holds the result of the word accepted in the previous cycle

Behaviour:
- Reset (rst=1 at a clk edge) clears all state:
  - out=0, out_valid=0
  - history register hist[2:0]=0
  - history-valid flag hv=0
  - rst has priority over in_valid.
- Word acceptance: a word is accepted on any clk edge with in_valid=1 and rst=0.
- Extended vector: ext = {hist, in}, 11 bits wide; ext[10] is the oldest bit.
- Match rule, for i=0..7: match[i] = (ext[i+3:i] == PATTERN).
  - Overlapping matches are all reported.
  - Example: 1010 inside 101010 gives two hits.
- History masking: when hv=0, match[i] is forced to 0 for i=5..7, i.e. any window that uses history bits.
- On acceptance, all of the following update at the same edge:
  - out <= match
  - out_valid <= 1
  - hist <= in[2:0]
  - hv <= 1
- Latency: exactly 1 cycle from acceptance to out/out_valid.
- Cycle with in_valid=0: out_valid <= 0; out, hist and hv hold their values. Gaps do not break cross-word detection.
- Back-to-back valid words are accepted every cycle; there is no backpressure.
- Reset mid-stream: the next word after reset behaves exactly as the first word after power-up, with history masked.

Optional Feature:
- Macro: INS_MATCH_COUNT_EN.
- When defined:
  - Adds output port match_cnt, 4 bits wide, registered.
  - match_cnt = population count of match, updated on the same edge as out.
  - Reset value 0; holds when in_valid=0.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then in=8'b01101010 with in_valid=1 -> next cycle out=8'b00000101, out_valid=1 (bits 5..7 masked).
- Next word in=8'b10101010 (hist=010) -> out=8'b01010101, showing a cross-word match at bit 6.
- Next word in=8'b00101010 (hist=010) -> out=8'b00000101. With INS_MATCH_COUNT_EN defined, match_cnt=2.
- Hold in_valid=0 for 3 cycles, then in=8'b10101010 -> out_valid=0 during the gap with out held; then out=8'b01010101, proving history is retained.
- Assert rst between words, then in=8'b10101010 -> out=8'b00010101 (history masked). out and out_valid read 0 in the cycle after reset.
- in=8'b11111111 then 8'b00000000 -> out=8'b00000000 for both words. With INS_MATCH_COUNT_EN defined, match_cnt=0.
